// File: rtl/pit_table.sv
// pit_table: NDN pending interest table, PIT end of the FIB->PIT data handshake.
// Optional per-entry expiry is enabled by defining PIT_LIFETIME_EN.
module pit_table #(
    parameter int ENTRIES    = 16,
    parameter int DATA_BYTES = 1024,
    parameter int FACE_W     = 4,
    parameter int LIFETIME   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prefix_ready,
    input  logic [63:0]       fib_prefix,
    input  logic [5:0]        fib_len,
    input  logic [7:0]        fib_data,
    output logic              start_send_to_pit,
    output logic              rejected,
    input  logic              interest_valid,
    input  logic [63:0]       interest_prefix,
    input  logic [5:0]        interest_len,
    input  logic [FACE_W-1:0] interest_face,
    output logic              interest_ready,
    output logic              interest_dropped,
    output logic              fib_out_bit,
    output logic [63:0]       pit_in_prefix,
    output logic [5:0]        pit_in_len,
    output logic [7:0]        data_out,
    output logic              data_out_valid,
    output logic [FACE_W-1:0] data_out_faces,
    output logic              data_last
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(DATA_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {IDLE, QSCAN, GRANT, XFER, ISCAN} state_t;
    state_t state, state_nx;

    logic              e_valid [ENTRIES];
    logic [63:0]       e_prefix[ENTRIES];
    logic [5:0]        e_len   [ENTRIES];
    logic [FACE_W-1:0] e_faces [ENTRIES];

    logic [63:0]       key_prefix;
    logic [5:0]        key_len;
    logic [FACE_W-1:0] key_face;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     hit_idx;
    logic [IW-1:0]     free_idx;
    logic              free_found;
    logic [CW-1:0]     cnt;

    logic              rej_q;
    logic              drop_q;
    logic              fout_q;
    logic [63:0]       pin_prefix_q;
    logic [5:0]        pin_len_q;
    logic [7:0]        dout_q;
    logic              dvalid_q;
    logic [FACE_W-1:0] dfaces_q;
    logic              dlast_q;

    function automatic logic prefix_eq(
        input logic [63:0] a,
        input logic [5:0]  la,
        input logic [63:0] b,
        input logic [5:0]  lb
    );
        logic [63:0] mask;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> la);
        return (la == lb) && (((a ^ b) & mask) == 64'd0);
    endfunction

    logic          scan_hit;
    logic          scan_last;
    logic          ins_ok;
    logic [IW-1:0] ins_idx;
    logic          xfer_last;

    assign scan_hit  = e_valid[scan_idx] &&
                       prefix_eq(e_prefix[scan_idx], e_len[scan_idx],
                                 key_prefix, key_len);
    assign scan_last = (scan_idx == LAST_IDX);
    assign ins_ok    = free_found || !e_valid[scan_idx];
    assign ins_idx   = free_found ? free_idx : scan_idx;
    assign xfer_last = (cnt == LAST_CNT);

`ifdef PIT_LIFETIME_EN
    localparam int LW = $clog2(LIFETIME + 1);
    logic [LW-1:0]      e_life[ENTRIES];
    logic [ENTRIES-1:0] pin;

    // the entry being granted or streamed must survive until satisfied
    always_comb begin
        pin = '0;
        if (state == GRANT || state == XFER)
            pin[hit_idx] = 1'b1;
        if (state == QSCAN && scan_hit)
            pin[scan_idx] = 1'b1;
    end
`else
    logic [31:0] unused_life;
    assign unused_life = LIFETIME;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (prefix_ready)
                    state_nx = QSCAN;
                else if (interest_valid)
                    state_nx = ISCAN;
            end
            QSCAN: begin
                if (scan_hit)
                    state_nx = GRANT;
                else if (scan_last)
                    state_nx = IDLE;
            end
            GRANT:
                state_nx = XFER;
            XFER: begin
                if (xfer_last)
                    state_nx = IDLE;
            end
            ISCAN: begin
                if (scan_hit || scan_last)
                    state_nx = IDLE;
            end
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_send_to_pit = (state == GRANT);
        interest_ready    = (state == IDLE) && !prefix_ready;
        rejected          = rej_q;
        interest_dropped  = drop_q;
        fib_out_bit       = fout_q;
        pit_in_prefix     = pin_prefix_q;
        pit_in_len        = pin_len_q;
        data_out          = dout_q;
        data_out_valid    = dvalid_q;
        data_out_faces    = dfaces_q;
        data_last         = dlast_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                e_valid[i]  <= 1'b0;
                e_prefix[i] <= '0;
                e_len[i]    <= '0;
                e_faces[i]  <= '0;
`ifdef PIT_LIFETIME_EN
                e_life[i]   <= '0;
`endif
            end
            key_prefix   <= '0;
            key_len      <= '0;
            key_face     <= '0;
            scan_idx     <= '0;
            hit_idx      <= '0;
            free_idx     <= '0;
            free_found   <= 1'b0;
            cnt          <= '0;
            rej_q        <= 1'b0;
            drop_q       <= 1'b0;
            fout_q       <= 1'b0;
            pin_prefix_q <= '0;
            pin_len_q    <= '0;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
            dfaces_q     <= '0;
            dlast_q      <= 1'b0;
        end else begin
            rej_q    <= 1'b0;
            drop_q   <= 1'b0;
            fout_q   <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dfaces_q <= '0;
            dlast_q  <= 1'b0;
`ifdef PIT_LIFETIME_EN
            for (int i = 0; i < ENTRIES; i++) begin
                if (e_valid[i] && !pin[i]) begin
                    if (e_life[i] <= LW'(1)) begin
                        e_valid[i] <= 1'b0;
                        e_life[i]  <= '0;
                    end else begin
                        e_life[i] <= e_life[i] - LW'(1);
                    end
                end
            end
`endif
            case (state)
                IDLE: begin
                    scan_idx   <= '0;
                    free_found <= 1'b0;
                    if (prefix_ready) begin
                        key_prefix <= fib_prefix;
                        key_len    <= fib_len;
                    end else if (interest_valid) begin
                        key_prefix <= interest_prefix;
                        key_len    <= interest_len;
                        key_face   <= interest_face;
                    end
                end
                QSCAN: begin
                    if (scan_hit)
                        hit_idx <= scan_idx;
                    else if (scan_last)
                        rej_q <= 1'b1;
                    else
                        scan_idx <= scan_idx + IW'(1);
                end
                GRANT:
                    cnt <= '0;
                XFER: begin
                    dout_q   <= fib_data;
                    dvalid_q <= 1'b1;
                    dfaces_q <= e_faces[hit_idx];
                    dlast_q  <= xfer_last;
                    cnt      <= cnt + CW'(1);
                    if (xfer_last)
                        e_valid[hit_idx] <= 1'b0;
                end
                ISCAN: begin
                    if (scan_hit) begin
                        e_faces[scan_idx] <= e_faces[scan_idx] | key_face;
                        e_valid[scan_idx] <= 1'b1;
`ifdef PIT_LIFETIME_EN
                        e_life[scan_idx]  <= LW'(LIFETIME);
`endif
                    end else begin
                        if (!e_valid[scan_idx] && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= scan_idx;
                        end
                        if (!scan_last) begin
                            scan_idx <= scan_idx + IW'(1);
                        end else if (ins_ok) begin
                            e_valid[ins_idx]  <= 1'b1;
                            e_prefix[ins_idx] <= key_prefix;
                            e_len[ins_idx]    <= key_len;
                            e_faces[ins_idx]  <= key_face;
`ifdef PIT_LIFETIME_EN
                            e_life[ins_idx]   <= LW'(LIFETIME);
`endif
                            fout_q       <= 1'b1;
                            pin_prefix_q <= key_prefix;
                            pin_len_q    <= key_len;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pit_table.sv
// tb_pit_table: randomized self-checking bench for pit_table.
// Reference model is a plain array of entries with first-match/lowest-free rules.
module tb_pit_table;
    localparam int ENTRIES    = 16;
    localparam int DATA_BYTES = 1024;
    localparam int FACE_W     = 4;
    localparam int LIFETIME   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prefix_ready = 1'b0;
    logic [63:0]       fib_prefix = '0;
    logic [5:0]        fib_len = '0;
    logic [7:0]        fib_data = '0;
    logic              start_send_to_pit;
    logic              rejected;
    logic              interest_valid = 1'b0;
    logic [63:0]       interest_prefix = '0;
    logic [5:0]        interest_len = '0;
    logic [FACE_W-1:0] interest_face = '0;
    logic              interest_ready;
    logic              interest_dropped;
    logic              fib_out_bit;
    logic [63:0]       pit_in_prefix;
    logic [5:0]        pit_in_len;
    logic [7:0]        data_out;
    logic              data_out_valid;
    logic [FACE_W-1:0] data_out_faces;
    logic              data_last;

    always #5 clk = ~clk;

    pit_table #(
        .ENTRIES(ENTRIES), .DATA_BYTES(DATA_BYTES),
        .FACE_W(FACE_W), .LIFETIME(LIFETIME)
    ) dut (
        .clk(clk), .rst(rst),
        .prefix_ready(prefix_ready), .fib_prefix(fib_prefix),
        .fib_len(fib_len), .fib_data(fib_data),
        .start_send_to_pit(start_send_to_pit), .rejected(rejected),
        .interest_valid(interest_valid), .interest_prefix(interest_prefix),
        .interest_len(interest_len), .interest_face(interest_face),
        .interest_ready(interest_ready), .interest_dropped(interest_dropped),
        .fib_out_bit(fib_out_bit), .pit_in_prefix(pit_in_prefix),
        .pit_in_len(pit_in_len), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_faces(data_out_faces),
        .data_last(data_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit               m_valid[ENTRIES];
    logic [63:0]      m_pre  [ENTRIES];
    int               m_len  [ENTRIES];
    logic [FACE_W-1:0] m_faces[ENTRIES];

    function automatic bit m_match(input logic [63:0] a, input int la,
                                   input logic [63:0] b, input int lb);
        int sh;
        if (la != lb) return 1'b0;
        if (la == 0) return 1'b1;
        sh = 64 - la;
        return (a >> sh) == (b >> sh);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic int m_find(input logic [63:0] p, input int l);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_match(m_pre[i], m_len[i], p, l)) return i;
        return -1;
    endfunction

    // 0 = merged, 1 = inserted, 2 = dropped
    function automatic int m_interest(input logic [63:0] p, input int l,
                                      input logic [FACE_W-1:0] f);
        int i;
        i = m_find(p, l);
        if (i >= 0) begin
            m_faces[i] |= f;
            return 0;
        end
        for (int j = 0; j < ENTRIES; j++) begin
            if (!m_valid[j]) begin
                m_valid[j] = 1'b1; m_pre[j] = p; m_len[j] = l; m_faces[j] = f;
                return 1;
            end
        end
        return 2;
    endfunction

    function automatic logic [87:0] outs();
        return {start_send_to_pit, rejected, interest_dropped, fib_out_bit,
                pit_in_prefix, pit_in_len, data_out, data_out_valid,
                data_out_faces, data_last};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
    endtask

    task automatic do_interest(input logic [63:0] p, input logic [5:0] l,
                               input logic [FACE_W-1:0] f);
        bit acc;
        int kind, nfo, ndr;
        logic [63:0] gp;
        logic [5:0] gl;
        acc = 1'b0; nfo = 0; ndr = 0; gp = '0; gl = '0;
        interest_valid = 1'b1; interest_prefix = p;
        interest_len = l; interest_face = f;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = interest_ready;
            @(posedge clk); #1;
        end
        interest_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL interest_accept got no handshake want handshake within 40 cycles");
        end
        kind = m_interest(p, int'(l), f);
        for (int k = 0; k < ENTRIES + 4; k++) begin
            @(negedge clk);
            if (fib_out_bit) begin nfo++; gp = pit_in_prefix; gl = pit_in_len; end
            if (interest_dropped) ndr++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (nfo != ((kind == 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL interest_fib_out pulses got %0d want %0d (prefix %h len %0d)",
                     nfo, (kind == 1) ? 1 : 0, p, l);
        end
        n_checks++;
        if (ndr != ((kind == 2) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL interest_dropped pulses got %0d want %0d", ndr, (kind == 2) ? 1 : 0);
        end
        if (kind == 1 && nfo == 1) begin
            n_checks++;
            if (gp !== p || gl !== l) begin
                n_fail++;
                $display("FAIL pit_in got %h/%0d want %h/%0d", gp, gl, p, l);
            end
        end
    endtask

    task automatic run_stream(input logic [FACE_W-1:0] faces, input int abort_at);
        logic [7:0] q[DATA_BYTES];
        int bad_v, bad_d, bad_f, bad_l;
        bit stop, ev;
        bad_v = 0; bad_d = 0; bad_f = 0; bad_l = 0; stop = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= DATA_BYTES + 1 && !stop; k++) begin
            if (k <= DATA_BYTES) begin
                q[k-1] = 8'($urandom);
                fib_data = q[k-1];
            end else begin
                fib_data = 8'($urandom);
            end
            if (k == abort_at) rst = 1'b1;
            @(negedge clk);
            ev = (k >= 2);
            if (data_out_valid !== ev) bad_v++;
            if (ev) begin
                if (data_out !== q[k-2]) bad_d++;
                if (data_out_faces !== faces) bad_f++;
                if (data_last !== (k == DATA_BYTES + 1)) bad_l++;
            end else if (data_last !== 1'b0) begin
                bad_l++;
            end
            @(posedge clk); #1;
            if (k == abort_at) begin rst = 1'b0; stop = 1'b1; end
        end
        fib_data = '0;
        n_checks++;
        if (bad_v != 0) begin n_fail++; $display("FAIL stream_valid bad cycles got %0d want 0", bad_v); end
        n_checks++;
        if (bad_d != 0) begin n_fail++; $display("FAIL stream_data bad bytes got %0d want 0", bad_d); end
        n_checks++;
        if (bad_f != 0) begin n_fail++; $display("FAIL stream_faces bad bytes got %0d want 0 (faces %b)", bad_f, faces); end
        n_checks++;
        if (bad_l != 0) begin n_fail++; $display("FAIL stream_last bad cycles got %0d want 0", bad_l); end
    endtask

    task automatic do_query(input logic [63:0] p, input logic [5:0] l, input int abort_at);
        int idx, exp_k, got_k;
        bit got_hit;
        idx = m_find(p, int'(l));
        exp_k = (idx >= 0) ? 2 + idx : ENTRIES + 1;
        got_k = 0; got_hit = 1'b0;
        prefix_ready = 1'b1; fib_prefix = p; fib_len = l;
        @(negedge clk);
        n_checks++;
        if (interest_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL query_blocks_interest interest_ready got %b want 0", interest_ready);
        end
        @(posedge clk); #1;
        prefix_ready = 1'b0;
        for (int k = 1; k <= ENTRIES + 4 && got_k == 0; k++) begin
            @(negedge clk);
            if (start_send_to_pit) begin got_k = k; got_hit = 1'b1; end
            else if (rejected) got_k = k;
            if (got_k == 0) begin @(posedge clk); #1; end
        end
        n_checks++;
        if (got_hit != (idx >= 0) || got_k != exp_k) begin
            n_fail++;
            $display("FAIL query_result got hit=%0d at T+%0d want hit=%0d at T+%0d (prefix %h len %0d)",
                     got_hit, got_k, idx >= 0, exp_k, p, l);
        end
        if (got_hit) begin
            run_stream((idx >= 0) ? m_faces[idx] : '0, abort_at);
            if (abort_at > 0) m_clear();
            else if (idx >= 0) m_valid[idx] = 1'b0;
        end else if (got_k != 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", outs());
        end
        n_checks++;
        if (interest_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_interest_ready got %b want 1", interest_ready);
        end
        @(posedge clk); #1;
        do_query({$urandom, $urandom}, 6'($urandom_range(0, 63)), 0);
    endtask

    task automatic test_merge();
        do_interest({16'hABCD, 48'h0}, 6'd16, 4'b0001);
        do_interest({16'hABCD, 48'h0}, 6'd16, 4'b0010);
    endtask

    task automatic test_xfer();
        n_checks++;
        if (m_find({32'hABCDFFFF, 32'h0}, 16) < 0 || m_faces[0] !== 4'b0011) begin
            n_fail++;
            $display("FAIL model_setup faces got %b want 0011", m_faces[0]);
        end
        do_query({32'hABCDFFFF, 32'h0}, 6'd16, 0);
        do_query({32'hABCDFFFF, 32'h0}, 6'd16, 0);
    endtask

    task automatic test_fill();
        int idx;
        apply_reset();
        for (int i = 0; i < ENTRIES + 1; i++) begin
            logic [63:0] p;
            logic [5:0] l;
            do begin
                p = {$urandom, $urandom};
                l = 6'($urandom_range(1, 63));
            end while (m_find(p, int'(l)) >= 0);
            do_interest(p, l, FACE_W'(1 << (i % FACE_W)));
        end
        idx = $urandom_range(0, ENTRIES - 1);
        do_query(m_pre[idx], 6'(m_len[idx]), 0);
        do_interest({8'hC3, 56'h0}, 6'd40, 4'b1000);
        do_query({8'hC3, 56'h0}, 6'd40, 0);
    endtask

    task automatic test_len0();
        apply_reset();
        do_interest({$urandom, $urandom}, 6'd0, 4'b0100);
        do_interest({16'h5A5A, 48'h0}, 6'd16, 4'b0001);
        do_query({16'h5A5A, 48'h0}, 6'd17, 0);
        do_query({$urandom, $urandom}, 6'd0, 0);
        do_query({$urandom, $urandom}, 6'd0, 0);
    endtask

    task automatic test_collision();
        logic [63:0] a, b, c, gp;
        int k_rej, nfo, kind;
        a = {16'h1234, 48'h0}; b = {8'h77, 56'h0}; c = {16'h5678, 48'h0};
        apply_reset();
        do_interest(a, 6'd16, 4'b0001);
        prefix_ready = 1'b1; fib_prefix = c; fib_len = 6'd16;
        interest_valid = 1'b1; interest_prefix = b;
        interest_len = 6'd8; interest_face = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (interest_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready got %b want 0", interest_ready);
        end
        @(posedge clk); #1;
        prefix_ready = 1'b0;
        k_rej = 0;
        for (int k = 1; k <= ENTRIES + 4 && k_rej == 0; k++) begin
            @(negedge clk);
            if (rejected) k_rej = k;
            @(posedge clk); #1;
        end
        interest_valid = 1'b0;
        n_checks++;
        if (k_rej != ENTRIES + 1) begin
            n_fail++;
            $display("FAIL collision_query rejected at T+%0d want T+%0d", k_rej, ENTRIES + 1);
        end
        kind = m_interest(b, 8, 4'b0010);
        nfo = 0; gp = '0;
        for (int k = 0; k < ENTRIES + 4; k++) begin
            @(negedge clk);
            if (fib_out_bit) begin nfo++; gp = pit_in_prefix; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (nfo != ((kind == 1) ? 1 : 0) || (nfo == 1 && gp !== b)) begin
            n_fail++;
            $display("FAIL collision_interest fib_out %0d prefix %h want 1 prefix %h", nfo, gp, b);
        end
        do_query(b, 6'd8, 0);
    endtask

    task automatic test_random();
        logic [63:0] base[4];
        int lens[3];
        lens[0] = 8; lens[1] = 16; lens[2] = 24;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            base[i] = {$urandom, $urandom};
            base[i][63:56] = 8'(i * 37 + 1);
        end
        for (int n = 0; n < 40; n++) begin
            logic [5:0] l;
            logic [63:0] noise, p;
            l = 6'(lens[$urandom_range(0, 2)]);
            noise = {$urandom, $urandom};
            p = base[$urandom_range(0, 3)] ^ (noise >> l);
            if ($urandom_range(0, 99) < 60)
                do_interest(p, l, FACE_W'(1 << $urandom_range(0, FACE_W - 1)));
            else
                do_query(p, l, 0);
        end
    endtask

    task automatic test_reset_midxfer();
        apply_reset();
        do_interest({16'hBEEF, 48'h0}, 6'd16, 4'b0011);
        do_query({16'hBEEF, 48'h0}, 6'd16, 500);
        @(negedge clk);
        n_checks++;
        if (outs() !== '0 || interest_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midxfer_reset outputs got %h ready %b want 0 ready 1", outs(), interest_ready);
        end
        @(posedge clk); #1;
        do_query({16'hBEEF, 48'h0}, 6'd16, 0);
    endtask

`ifdef PIT_LIFETIME_EN
    task automatic test_lifetime();
        apply_reset();
        do_interest({16'h1111, 48'h0}, 6'd16, 4'b0001);
        do_query({16'h1111, 48'h0}, 6'd16, 0);
        do_interest({16'h2222, 48'h0}, 6'd16, 4'b0100);
        repeat (LIFETIME + 16) begin @(posedge clk); #1; end
        m_clear();
        do_query({16'h2222, 48'h0}, 6'd16, 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_merge();
        test_xfer();
`ifdef PIT_LIFETIME_EN
        test_lifetime();
`else
        test_fill();
        test_len0();
        test_collision();
        test_random();
        test_reset_midxfer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
